// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch/execute constants: the NOP bubble encoding, pipeline depth
// between fetch and execute, and the default boot address.
package pc_fetch_unit_pkg;

  // addi x0, x0, 0 -- the canonical bubble presented to execute
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Register stages between fetch_pc and execute (f1 and E)
  localparam int unsigned PIPELINE_STAGES = 2;

  // Default first fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Word step between sequential fetches
  localparam logic [31:0] PC_STEP = 32'h0000_0004;

  // A jump target is misaligned when its byte-offset bits are non-zero
  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_target_calc.sv
// Jump target calculation: relative (fetch_pc + offset) or absolute target,
// word-aligned result plus a flag for a non-word-aligned request.
module pc_target_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] fetch_pc_i,
  input  logic [W-1:0] jump_offset_i,
  input  logic         not_relative_i,
  output logic [W-1:0] target_aligned_o,
  output logic         misaligned_o
);

  logic [W-1:0] target_s;

  // Select target source, force word alignment and flag dropped low bits
  always_comb begin
    if (not_relative_i) begin
      target_s = jump_offset_i;
    end else begin
      target_s = fetch_pc_i + jump_offset_i;
    end
    target_aligned_o = {target_s[W-1:2], 2'b00};
    misaligned_o     = addr_misaligned(target_s[1:0]);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Three-stage instruction fetch: fetch_pc (F), address in flight (f1),
// instruction to execute (E). A one-entry skid register keeps the word that
// returns on the first stall cycle, since the memory is not re-read while
// stalled.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned              INSTR_LENGTH = 32,
  parameter logic [INSTR_LENGTH-1:0]  RESET_PC     = INSTR_LENGTH'(RESET_PC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pc_jump,
  input  logic                    not_relative_pc,
  input  logic [INSTR_LENGTH-1:0] jump_offset,
  input  logic                    stall,
  output logic [INSTR_LENGTH-1:0] imem_addr,
  output logic                    imem_req,
  input  logic [INSTR_LENGTH-1:0] imem_rdata,
  output logic [INSTR_LENGTH-1:0] instr,
  output logic [INSTR_LENGTH-1:0] instr_pc,
  output logic                    instr_valid,
  output logic                    misalign_err
);

  localparam logic [INSTR_LENGTH-1:0] NOP_W  = INSTR_LENGTH'(NOP_INSTR);
  localparam logic [INSTR_LENGTH-1:0] STEP_W = INSTR_LENGTH'(PC_STEP);
  localparam logic [INSTR_LENGTH-1:0] ZERO_W = {INSTR_LENGTH{1'b0}};

  logic [INSTR_LENGTH-1:0] fetch_pc_q,    fetch_pc_d;
  logic [INSTR_LENGTH-1:0] f1_pc_q,       f1_pc_d;
  logic                    f1_valid_q,    f1_valid_d;
  logic [INSTR_LENGTH-1:0] instr_q,       instr_d;
  logic [INSTR_LENGTH-1:0] instr_pc_q,    instr_pc_d;
  logic                    instr_valid_q, instr_valid_d;
  logic [INSTR_LENGTH-1:0] skid_q,        skid_d;
  logic                    skid_valid_q,  skid_valid_d;
  logic                    misalign_q,    misalign_d;

  logic [INSTR_LENGTH-1:0] target_aligned_s;
  logic                    misaligned_s;
  logic [INSTR_LENGTH-1:0] f1_data_s;

  pc_target_calc #(
    .W (INSTR_LENGTH)
  ) u_target_calc (
    .fetch_pc_i       (fetch_pc_q),
    .jump_offset_i    (jump_offset),
    .not_relative_i   (not_relative_pc),
    .target_aligned_o (target_aligned_s),
    .misaligned_o     (misaligned_s)
  );

  // Word belonging to f1_pc: the skid copy if a stall parked it, else live data
  always_comb begin
    if (skid_valid_q) begin
      f1_data_s = skid_q;
    end else begin
      f1_data_s = imem_rdata;
    end
  end

  // Next-state: hold on stall, redirect on jump, otherwise advance one word
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    f1_pc_d       = f1_pc_q;
    f1_valid_d    = f1_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;
    misalign_d    = 1'b0;

    if (stall) begin
      // Only the first stall cycle carries the word requested for f1_pc
      if (!skid_valid_q) begin
        skid_d       = imem_rdata;
        skid_valid_d = 1'b1;
      end else begin
        skid_d       = skid_q;
        skid_valid_d = 1'b1;
      end
    end else if (pc_jump) begin
      fetch_pc_d    = target_aligned_s;
      f1_valid_d    = 1'b0;
      instr_d       = NOP_W;
      instr_pc_d    = f1_pc_q;
      instr_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      misalign_d    = misaligned_s;
    end else begin
      fetch_pc_d   = fetch_pc_q + STEP_W;
      f1_pc_d      = fetch_pc_q;
      f1_valid_d   = 1'b1;
      instr_pc_d   = f1_pc_q;
      skid_valid_d = 1'b0;
      if (f1_valid_q) begin
        instr_d       = f1_data_s;
        instr_valid_d = 1'b1;
      end else begin
        instr_d       = NOP_W;
        instr_valid_d = 1'b0;
      end
    end
  end

  // Pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      f1_pc_q       <= ZERO_W;
      f1_valid_q    <= 1'b0;
      instr_q       <= NOP_W;
      instr_pc_q    <= ZERO_W;
      instr_valid_q <= 1'b0;
      skid_q        <= ZERO_W;
      skid_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      f1_pc_q       <= f1_pc_d;
      f1_valid_q    <= f1_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_addr    = fetch_pc_q;
  assign imem_req     = rst & ~stall;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = instr_valid_q;
  assign misalign_err = misalign_q;

endmodule
